// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : sw_debounce
//  Description : Per-bit switch conditioning. Each raw switch input is
//                synchronised (two flops), debounced with a stability
//                counter, edge-detected into registered rise/fall pulses,
//                and rising edges are latched into sticky pending flags
//                until acknowledged.
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce #(
    parameter int WIDTH         = 10,
    parameter int STABLE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,       // asynchronous, active-low
    input  logic [WIDTH-1:0] sw,
    input  logic [WIDTH-1:0] ack,
    output logic [WIDTH-1:0] sw_clear,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] evt_pend,
    output logic             any_pend
);

    localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] clear_q, clear_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Next-state: synchroniser shift, debounce counters, edge pulses and pending flags
    always_comb begin
        s1_d    = sw;
        s2_d    = s1_q;
        clear_d = clear_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
            if (s2_q[i] == clear_q[i]) begin
                // Input agrees with the accepted level: any bounce restarts the count
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                // Input has disagreed long enough: accept it and flag the edge
                cnt_d[i]   = '0;
                clear_d[i] = s2_q[i];
                rise_d[i]  = s2_q[i];
                fall_d[i]  = ~s2_q[i];
            end
        end
        // A new rising event beats a simultaneous acknowledge so nothing is lost
        pend_d = rise_d | (pend_q & ~ack);
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            clear_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            pend_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            clear_q <= clear_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            pend_q  <= pend_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_clear = clear_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign evt_pend = pend_q;
    // OR of registers only, so it cannot glitch on input activity
    assign any_pend = |pend_q;

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sw_debounce
//  Description : Self-checking bench for sw_debounce. A window-based model
//                decides acceptance from the history of synchronised input
//                values; a compare process checks every cycle, and directed
//                scenarios pin exact latencies with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_debounce;

    localparam int W = 10;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw;
    logic [W-1:0] ack;
    logic [W-1:0] sw_clear;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] evt_pend;
    logic         any_pend;

    int checks = 0;
    int errors = 0;

    sw_debounce #(
        .WIDTH        (W),
        .STABLE_CYCLES(S)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .sw      (sw),
        .ack     (ack),
        .sw_clear(sw_clear),
        .rise    (rise),
        .fall    (fall),
        .evt_pend(evt_pend),
        .any_pend(any_pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a level is accepted once the synchronised input
    // (the switch as sampled two edges earlier) has disagreed with the
    // accepted level over the last S edges, all since the previous change.
    // ------------------------------------------------------------------
    logic [W-1:0] m_clr  = '0;
    logic [W-1:0] m_rise = '0;
    logic [W-1:0] m_fall = '0;
    logic [W-1:0] m_pend = '0;
    logic [W-1:0] swq[$];
    logic [W-1:0] win[$];
    int           since[W];

    always @(posedge clk or negedge rst) begin
        logic [W-1:0] s2pre;
        logic [W-1:0] acc;
        logic         ok;
        if (!rst) begin
            m_clr  = '0;
            m_rise = '0;
            m_fall = '0;
            m_pend = '0;
            swq.delete();
            win.delete();
            for (int i = 0; i < W; i++) since[i] = 0;
        end else begin
            s2pre = (swq.size() == 2) ? swq[0] : '0;
            swq.push_back(sw);
            if (swq.size() > 2) void'(swq.pop_front());
            win.push_back(s2pre);
            if (win.size() > S) void'(win.pop_front());
            acc = '0;
            for (int i = 0; i < W; i++) begin
                since[i]++;
                if (since[i] >= S) begin
                    ok = 1'b1;
                    foreach (win[j]) if (win[j][i] == m_clr[i]) ok = 1'b0;
                    if (ok) begin
                        acc[i]   = 1'b1;
                        since[i] = 0;
                    end
                end
            end
            m_rise = acc & ~m_clr;
            m_fall = acc & m_clr;
            m_pend = m_rise | (m_pend & ~ack);
            m_clr  = m_clr ^ acc;
        end
    end

    // Every-cycle comparison away from the active edge
    always @(negedge clk) begin
        chk("cmp_sw_clear", sw_clear, m_clr);
        chk("cmp_rise", rise, m_rise);
        chk("cmp_fall", fall, m_fall);
        chk("cmp_evt_pend", evt_pend, m_pend);
        chk("cmp_any_pend", any_pend, |m_pend);
    end

    initial begin
        sw  = '0;
        ack = '0;
        rst = 1'b1;
        #1 rst = 1'b0;

        // Idle after reset
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_outputs", {sw_clear, rise, fall, evt_pend, any_pend}, 64'd0);

        // Clean press on bit 0: accepted at E6
        @(negedge clk); sw[0] = 1'b1;
        repeat (5) @(posedge clk);
        #2 chk("press_before_e6", sw_clear[0], 1'b0);
        @(posedge clk);
        #2;
        chk("press_clear", sw_clear[0], 1'b1);
        chk("press_rise", rise[0], 1'b1);
        chk("press_pend", evt_pend[0], 1'b1);
        chk("press_any", any_pend, 1'b1);
        chk("press_fall", fall, 64'd0);
        @(posedge clk);
        #2;
        chk("press_rise_gone", rise[0], 1'b0);
        chk("press_pend_held", evt_pend[0], 1'b1);

        // Acknowledge bit 0
        @(negedge clk); ack[0] = 1'b1;
        @(negedge clk); ack[0] = 1'b0;
        chk("ack_pend", evt_pend[0], 1'b0);
        chk("ack_any", any_pend, 1'b0);

        // Bounce rejection on bit 3, then a stable press
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); sw[3] = (k % 2 == 0);
            @(negedge clk);
        end
        chk("bounce_clear", sw_clear[3], 1'b0);
        @(negedge clk); sw[3] = 1'b1;
        repeat (5) @(posedge clk);
        #2 chk("bounce_no_early_rise", rise[3], 1'b0);
        @(posedge clk);
        #2 chk("bounce_rise", rise[3], 1'b1);

        // Set and ack on the same edge for bit 5
        @(negedge clk); sw[5] = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk); ack[5] = 1'b1;
        @(posedge clk);
        #2;
        chk("setack_rise", rise[5], 1'b1);
        chk("setack_pend", evt_pend[5], 1'b1);
        @(negedge clk); ack[5] = 1'b0;
        @(posedge clk);
        #2 chk("setack_pend_held", evt_pend[5], 1'b1);

        // Release bit 0
        @(negedge clk); sw[0] = 1'b0;
        repeat (5) @(posedge clk);
        #2 chk("release_no_early_fall", fall[0], 1'b0);
        @(posedge clk);
        #2;
        chk("release_fall", fall[0], 1'b1);
        chk("release_clear", sw_clear[0], 1'b0);
        chk("release_pend", evt_pend[0], 1'b0);
        chk("release_rise", rise[0], 1'b0);

        // Asynchronous reset mid-count on bit 2, released with switch held
        @(negedge clk); sw[2] = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("async_rst_zero", {sw_clear, rise, fall, evt_pend, any_pend}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #2 chk("poweron_no_early_rise", rise[2], 1'b0);
        @(posedge clk);
        #2;
        chk("poweron_rise", rise[2], 1'b1);
        chk("poweron_pend", evt_pend[2], 1'b1);

        // Randomised traffic with one asynchronous reset in the middle
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) begin
                @(posedge clk);
                #2 rst = 1'b0;
                #1 chk("rand_rst_zero", {sw_clear, rise, fall, evt_pend, any_pend}, 64'd0);
                @(negedge clk); rst = 1'b1;
            end
            @(negedge clk);
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(7) == 0) sw[i] = ~sw[i];
            end
            ack = W'($urandom & $urandom & $urandom);
        end
        @(negedge clk); ack = '0;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sw_debounce.md
# sw_debounce

Switch-conditioning stage that sits directly upstream of the traffic-light controller. It takes the raw board slide switches and produces the clean `sw_clear` bus that the controller consumes. Each bit is synchronised, debounced and edge-detected on the fast board clock. Rising edges are held in sticky pending flags until acknowledged, so a controller running on the divided clock never misses a short request.

## Interface
Parameters:
- `WIDTH`, 10: number of switch bits.
- `STABLE_CYCLES`, 500000: consecutive `clk` cycles a synchronised input must differ from `sw_clear` before it is accepted. The default is 10 ms at 50 MHz. Must be ≥ 1. The counter width is derived internally as `$clog2(STABLE_CYCLES+1)`.

Ports:
- `clk`, in, 1: board clock; the only clock in the block.
- `rst`, in, 1: asynchronous, active-low reset.
- `sw`, in, WIDTH: raw asynchronous switch inputs.
- `ack`, in, WIDTH: per-bit clear of `evt_pend`, synchronous to `clk`.
- `sw_clear`, out, WIDTH: debounced switch levels.
- `rise`, out, WIDTH: one-cycle pulse when a `sw_clear` bit goes 0→1.
- `fall`, out, WIDTH: one-cycle pulse when a `sw_clear` bit goes 1→0.
- `evt_pend`, out, WIDTH: sticky rising-event flags.
- `any_pend`, out, 1: OR of all `evt_pend` bits.

## Operation
Each bit is handled independently; there is no cross-bit interaction.

- **Synchroniser:** two flops, `s1` then `s2`. Both reset to 0.
- **Debounce counter `cnt[i]`:**
  - If `s2[i] == sw_clear[i]`, then `cnt[i] <= 0`. Any bounce back to the accepted level restarts the count.
  - If `s2[i] != sw_clear[i]` and `cnt[i] == STABLE_CYCLES-1`, then `sw_clear[i] <= s2[i]` and `cnt[i] <= 0`.
  - Otherwise `cnt[i] <= cnt[i]+1`.
  - The counter never exceeds `STABLE_CYCLES-1`, so no wrap-around is possible.
- **Edge pulses:** `rise[i]` and `fall[i]` are registered. Each is high for exactly the one cycle following the `sw_clear[i]` update, and the two are never high together.
- **Pending flags:**
  - `evt_pend[i]` is set on the edge where `sw_clear[i]` goes 0→1, i.e. the same edge that sets `rise[i]`.
  - It is cleared on an edge where `ack[i]=1` and no set occurs.
  - If a set and `ack[i]` occur on the same edge, the set wins and the flag stays 1, so no event is lost.
  - `ack` on a bit whose flag is already 0 has no effect.
  - A falling edge does not touch `evt_pend`.
- **Combined flag:** `any_pend` is the combinational OR of the `evt_pend` registers and is glitch-free.
- **Reset (`rst`=0, at any time, including mid-count):**
  - All flops clear immediately and asynchronously: `s1`, `s2`, `cnt`, `sw_clear`, `rise`, `fall` and `evt_pend` are all 0, and `any_pend` is 0.
  - After release, a switch already held at 1 is treated as a fresh 0→1 change. It produces `rise` and sets `evt_pend` after the normal latency.

## Timing
- **Latency:** let E1 be the first `clk` edge that samples a new stable `sw[i]` level.
  - `s2[i]` updates at E2.
  - `sw_clear[i]` updates at edge E(`STABLE_CYCLES`+2).
  - `rise[i]` or `fall[i]` is high for the cycle following that edge.
  - `evt_pend[i]` is visible in that same cycle.
- **Minimum stability:** pulses on `sw` shorter than `STABLE_CYCLES` cycles, measured at `s2`, are rejected entirely.
- **Acknowledge:** `ack[i]` high at edge N clears `evt_pend[i]`; it reads 0 after edge N. The acknowledging side may hold `ack` high for several cycles; this is harmless except that it would hide a new event arriving during that window only if `ack` stays high after the set edge. The consumer must therefore drop `ack` once it sees `evt_pend[i]=0`.
- **Throughput:** all WIDTH bits may change in the same cycle. Their outputs update together when their counters expire together.

## Test plan
All scenarios run with `STABLE_CYCLES`=4 and `WIDTH`=10.
1. **Idle after reset:** hold `rst`=0 for 3 cycles with `sw`=0, release, run 20 cycles → every output stays 0.
2. **Clean press:** `sw[0]` goes 0→1 before edge E1 → `sw_clear[0]`=1 after E6. `rise[0]`=1 for exactly the cycle after E6. `evt_pend[0]`=1 and `any_pend`=1 from that cycle. `fall` stays 0.
3. **Bounce rejection:** `sw[3]` toggles every 2 cycles for 20 cycles, then holds 1 → no change on `sw_clear[3]` during the toggling. Exactly one `rise[3]` pulse, 6 edges after the final transition.
4. **Acknowledge:**
   - With `evt_pend[0]`=1, pulse `ack[0]` for 1 cycle → `evt_pend[0]`=0 and `any_pend`=0 on the next cycle.
   - Repeat with `ack[5]` asserted on the same edge that sets `evt_pend[5]` → `evt_pend[5]` remains 1.
5. **Release:** `sw[0]` goes 1→0 → `fall[0]` pulses once at E6 and `sw_clear[0]`=0. `evt_pend[0]` is unchanged.
6. **Async reset mid-count and at power-up with switch on:**
   - Assert `rst`=0 between edges while `cnt[2]`=2 → all outputs read 0 before the next edge.
   - Release with `sw[2]`=1 held → `rise[2]` pulses after E6 and `evt_pend[2]` is set.
